// File: rtl/fsm_arbiter_rr.sv
// fsm_arbiter_rr: N-agent grant arbiter with fixed-priority or round-robin
// selection, bounded hold time with preemption and back-to-back handoff.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      synchronous, active-high reset
//   req_i        per-agent level request (bit i = agent i)
//   rr_mode_i    0 = fixed priority (lowest index wins), 1 = round-robin
//   gnt_o        registered one-hot grant, zero when idle
//   gnt_valid_o  registered, high iff gnt_o is non-zero
//   gnt_id_o     registered owner index, holds last owner while idle
//   preempt_o    registered pulse in the first cycle after a hold-limit handoff
module fsm_arbiter_rr #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               rr_mode_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IDW-1:0]     gnt_id_o,
    output logic               preempt_o
);

    // MAX_HOLD = 0 means unlimited; keep a 1-bit counter so the width never collapses.
    localparam int unsigned HW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               preempt_q, preempt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    // Pick one winner among cand: lowest index, or first index after ptr (wrapping).
    function automatic logic [IDW-1:0] arb_pick(input logic [NUM_REQ-1:0] cand,
                                                input logic               rr,
                                                input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] win;
        logic           found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = rr ? (32'(ptr) + 32'(k) + 32'd1) % NUM_REQ : 32'(k);
            if (!found && cand[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        return win;
    endfunction

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            hold_q      <= '0;
            rr_ptr_q    <= IDW'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        logic [NUM_REQ-1:0] owner_mask;
        logic [NUM_REQ-1:0] others;
        logic [IDW-1:0]     w_all;
        logic [IDW-1:0]     w_oth;

        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = 1'b0;
        hold_d      = hold_q;
        rr_ptr_d    = rr_ptr_q;

        owner_mask = NUM_REQ'(1) << gnt_id_q;
        others     = req_i & ~owner_mask;
        w_all      = arb_pick(req_i, rr_mode_i, rr_ptr_q);
        w_oth      = arb_pick(others, rr_mode_i, rr_ptr_q);

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (|req_i) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << w_all;
                    gnt_id_d    = w_all;
                    gnt_valid_d = 1'b1;
                    hold_d      = HW'(1);
                    rr_ptr_d    = w_all;
                end
            end
            GRANT: begin
                if (!req_i[gnt_id_q]) begin
                    // Owner released: hand off directly or fall idle.
                    if (|others) begin
                        gnt_d    = NUM_REQ'(1) << w_oth;
                        gnt_id_d = w_oth;
                        hold_d   = HW'(1);
                        rr_ptr_d = w_oth;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                        hold_d      = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) && (|others)) begin
                    // Hold limit reached with a waiter: force a handoff.
                    gnt_d     = NUM_REQ'(1) << w_oth;
                    gnt_id_d  = w_oth;
                    hold_d    = HW'(1);
                    rr_ptr_d  = w_oth;
                    preempt_d = 1'b1;
                end else if (hold_q != HW'(HOLD_SAT)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                // Illegal encoding: return to idle with outputs cleared.
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                hold_d      = '0;
                rr_ptr_d    = IDW'(NUM_REQ - 1);
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = gnt_id_q;
    assign preempt_o   = preempt_q;

endmodule
